hbridge_pwm_gen: RTL and testbench

Parametrised full-bridge gate driver for the SWIPT transmitter. It generates the four bridge gate signals (two high-side, two low-side) at a programmable period and on-time, with a programmable break-before-make dead time. Period, on-time and dead time sit in shadow registers and are applied only at period boundaries, so the frequency and power-control logic can retune the bridge while it runs without producing glitched half-cycles.

---
 rtl/hbridge_pwm_gen.sv | 173 +++++++++++++++++
 tb/tb_hbridge_pwm_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hbridge_pwm_gen.sv
// rtl/hbridge_pwm_gen.sv - full-bridge gate driver with shadowed period/on-time/dead-time
// Raw leg requests are registered with the period counter; per-gate qualifiers add break-before-make delay.
module hbridge_pwm_gen #(
  parameter int CNT_W      = 16,
  parameter int DT_W       = 4,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_PULSE  = 48,
  parameter int DEF_DEAD   = 14
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] pulse,
  input  logic [DT_W-1:0]  dead,
  output logic             hs_a,
  output logic             hs_b,
  output logic             ls_a,
  output logic             ls_b,
  output logic             period_start,
  output logic             cfg_pending,
  output logic             cfg_err
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);
  localparam logic [DT_W-1:0]  Q_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_per, r_pul, r_per_s, r_pul_s;
  logic [CNT_W-1:0] w_per_nxt, w_pul_nxt, w_per_s_nxt, w_pul_s_nxt;
  logic [DT_W-1:0]  r_dt, r_dt_s, w_dt_nxt, w_dt_s_nxt;
  logic             r_pend, r_err, w_pend_nxt, w_err_nxt;
  logic             r_rhs_a, r_rhs_b, r_rls_a, r_rls_b;
  logic             w_rhs_a_nxt, w_rhs_b_nxt;
  logic             w_load, w_err_set;
  logic [CNT_W-1:0] w_half, w_we;
  logic [3:0]       w_raw, w_gate;
  logic [DT_W-1:0]  r_q [4];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_per   <= CNT_W'(DEF_PERIOD);
      r_pul   <= CNT_W'(DEF_PULSE);
      r_dt    <= DT_W'(DEF_DEAD);
      r_per_s <= CNT_W'(DEF_PERIOD);
      r_pul_s <= CNT_W'(DEF_PULSE);
      r_dt_s  <= DT_W'(DEF_DEAD);
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
      r_rhs_a <= 1'b0;
      r_rhs_b <= 1'b0;
      r_rls_a <= 1'b0;
      r_rls_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_per   <= w_per_nxt;
      r_pul   <= w_pul_nxt;
      r_dt    <= w_dt_nxt;
      r_per_s <= w_per_s_nxt;
      r_pul_s <= w_pul_s_nxt;
      r_dt_s  <= w_dt_s_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= w_err_nxt;
      r_rhs_a <= w_rhs_a_nxt;
      r_rhs_b <= w_rhs_b_nxt;
      r_rls_a <= ~w_rhs_a_nxt;
      r_rls_b <= ~w_rhs_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per;
    w_pul_nxt   = r_pul;
    w_dt_nxt    = r_dt;
    w_per_s_nxt = r_per_s;
    w_pul_s_nxt = r_pul_s;
    w_dt_s_nxt  = r_dt_s;
    w_pend_nxt  = r_pend;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    w_rhs_a_nxt = 1'b0;
    w_rhs_b_nxt = 1'b0;
    w_half      = '0;
    w_we        = '0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (en) begin
          if (r_per_s >= C_TWO) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= r_per - C_ONE) begin
          w_cnt_nxt = '0;
          if (r_pend) begin
            if (r_per_s >= C_TWO) w_load = 1'b1;
            else                  w_err_set = 1'b1;
            w_pend_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_per_nxt  = r_per_s;
      w_pul_nxt  = r_pul_s;
      w_dt_nxt   = r_dt_s;
      w_pend_nxt = 1'b0;
    end

    // A fresh valid write clears the error even if the old shadow is rejected this cycle
    if (cfg_wr && period >= C_TWO) w_err_nxt = 1'b0;
    else if (w_err_set)            w_err_nxt = 1'b1;

    if (cfg_wr) begin
      w_per_s_nxt = period;
      w_pul_s_nxt = pulse;
      w_dt_s_nxt  = dead;
      w_pend_nxt  = 1'b1;
    end

    if (w_state_nxt == ST_RUN) begin
      w_half      = w_per_nxt >> 1;
      w_we        = (w_pul_nxt < w_half) ? w_pul_nxt : w_half;
      w_rhs_a_nxt = (w_cnt_nxt < w_we);
      w_rhs_b_nxt = (w_cnt_nxt >= w_half) && ((w_cnt_nxt - w_half) < w_we);
    end
  end

  assign w_raw = {r_rhs_a, r_rhs_b, r_rls_a, r_rls_b};

  // Qualifiers saturate at full scale so a dead-time change still sees the true high run length
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!nrst || !w_raw[i]) r_q[i] <= '0;
      else if (r_q[i] != Q_MAX) r_q[i] <= r_q[i] + DT_W'(1);
    end
  end

  always_comb begin
    w_gate = '0;
    for (int i = 0; i < 4; i++) w_gate[i] = w_raw[i] && (r_q[i] >= r_dt);
  end

  assign {hs_a, hs_b, ls_a, ls_b} = w_gate;
  assign period_start = (r_state == ST_RUN) && (r_cnt == '0);
  assign cfg_pending  = r_pend;
  assign cfg_err      = r_err;

endmodule

// File: tb/tb_hbridge_pwm_gen.sv
// tb/tb_hbridge_pwm_gen.sv - directed and randomized bench against a cycle-level reference model
module tb_hbridge_pwm_gen;

  logic        clk = 1'b0;
  logic        nrst, en, cfg_wr;
  logic [15:0] period, pulse;
  logic [3:0]  dead;
  logic        hs_a, hs_b, ls_a, ls_b, period_start, cfg_pending, cfg_err;

  always #5 clk = ~clk;

  hbridge_pwm_gen #(
    .CNT_W(16), .DT_W(4), .DEF_PERIOD(100), .DEF_PULSE(48), .DEF_DEAD(14)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .cfg_wr(cfg_wr),
    .period(period), .pulse(pulse), .dead(dead),
    .hs_a(hs_a), .hs_b(hs_b), .ls_a(ls_a), .ls_b(ls_b),
    .period_start(period_start), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: period position, active/shadow config and raw-request history per gate
  int          m_run, m_cnt, m_p, m_w, m_d, m_ps, m_ws, m_ds;
  bit          m_pend, m_err;
  bit   [3:0]  m_raw;
  logic [31:0] m_hist [4];

  function automatic void model_reset();
    m_run = 0; m_cnt = 0;
    m_p = 100; m_w = 48; m_d = 14;
    m_ps = 100; m_ws = 48; m_ds = 14;
    m_pend = 0; m_err = 0; m_raw = 4'b0;
    for (int i = 0; i < 4; i++) m_hist[i] = 32'b0;
  endfunction

  function automatic void apply_shadow();
    m_p = m_ps; m_w = m_ws; m_d = m_ds;
  endfunction

  function automatic void model_step();
    bit set_e;
    int h, we;
    if (!nrst) begin
      model_reset();
      return;
    end
    set_e = 0;
    if (m_run == 0) begin
      m_cnt = 0;
      if (en) begin
        if (m_ps >= 2) begin apply_shadow(); m_pend = 0; m_run = 1; end
        else set_e = 1;
      end
    end else if (!en) begin
      m_run = 0; m_cnt = 0;
    end else if (m_cnt == m_p - 1) begin
      m_cnt = 0;
      if (m_pend) begin
        if (m_ps >= 2) apply_shadow();
        else set_e = 1;
        m_pend = 0;
      end
    end else begin
      m_cnt++;
    end
    if (cfg_wr && period >= 2) m_err = 0;
    else if (set_e)            m_err = 1;
    if (cfg_wr) begin
      m_ps = int'(period); m_ws = int'(pulse); m_ds = int'(dead); m_pend = 1;
    end
    // raw order: hs_a, hs_b, ls_a, ls_b
    if (m_run != 0) begin
      h  = m_p / 2;
      we = (m_w < h) ? m_w : h;
      m_raw[3] = (m_cnt < h) && (m_cnt < we);
      m_raw[2] = (m_cnt >= h) && ((m_cnt - h) < we);
      m_raw[1] = !m_raw[3];
      m_raw[0] = !m_raw[2];
    end else begin
      m_raw = 4'b0011;
    end
    for (int i = 0; i < 4; i++) m_hist[i] = {m_hist[i][30:0], m_raw[3-i]};
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [31:0] mask;
    logic [3:0]  g;
    mask = (32'd1 << (m_d + 1)) - 32'd1;
    for (int i = 0; i < 4; i++) g[3-i] = ((m_hist[i] & mask) == mask);
    return {g, (m_run != 0) && (m_cnt == 0), m_pend, m_err};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("outs", {25'b0, hs_a, hs_b, ls_a, ls_b, period_start, cfg_pending, cfg_err},
          {25'b0, exp_vec()});
    check("overlap", {30'b0, hs_a & ls_a, hs_b & ls_b}, 32'd0);
  endtask

  task automatic wr(input int p, input int w, input int d);
    cfg_wr = 1'b1; period = 16'(p); pulse = 16'(w); dead = 4'(d);
    cycle();
    cfg_wr = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input int c);
    int k;
    for (k = 0; k < 300 && !(m_run != 0 && m_cnt == c); k++) cycle();
    check(tag, {31'b0, k >= 300}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; cfg_wr = 1'b0; period = '0; pulse = '0; dead = '0;
    model_reset();
    repeat (3) cycle();
    check("rst_outs", {25'b0, hs_a, hs_b, ls_a, ls_b, period_start, cfg_pending, cfg_err}, 32'd0);
    nrst = 1'b1;
    repeat (20) cycle();
    check("idle_ls", {30'b0, ls_a, ls_b}, 32'd3);

    wr(10, 3, 0); en = 1'b1;
    repeat (40) cycle();

    en = 1'b0; repeat (3) cycle();
    wr(10, 3, 2); en = 1'b1;
    repeat (30) cycle();

    wait_cnt("wait_retune", 4);
    wr(20, 8, 2);
    check("retune_pending", {31'b0, cfg_pending}, 32'd1);
    repeat (60) cycle();

    wr(9, 7, 0);
    repeat (40) cycle();

    en = 1'b0; cycle();
    wr(1, 3, 0); en = 1'b1;
    repeat (10) cycle();
    check("err_idle", {27'b0, cfg_err, ls_a, ls_b, hs_a, hs_b}, 32'b11100);
    wr(10, 5, 1);
    repeat (20) cycle();

    wait_cnt("wait_drop", 1);
    en = 1'b0; cycle();
    check("en_drop", {30'b0, hs_a, hs_b}, 32'd0);
    en = 1'b1; repeat (15) cycle();

    wait_cnt("wait_rst", 6);
    nrst = 1'b0; cycle();
    check("rst_mid", {25'b0, hs_a, hs_b, ls_a, ls_b, period_start, cfg_pending, cfg_err}, 32'd0);
    nrst = 1'b1;
    repeat (20) cycle();

    for (int i = 0; i < 3000; i++) begin
      cfg_wr = ($urandom_range(15) == 0);
      if (cfg_wr) begin
        period = 16'($urandom_range(40));
        pulse  = 16'($urandom_range(30));
        dead   = 4'($urandom_range(15));
      end
      if ($urandom_range(40) == 0) en = ~en;
      nrst = ($urandom_range(300) != 0);
      cycle();
    end
    nrst = 1'b1; cfg_wr = 1'b0;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
